btn_event: RTL and testbench
============================

# btn_event

Per-button event generator that sits directly downstream of the button debouncer. It takes debounced, `sclk`-synchronous button levels and turns each one into single-cycle event pulses: press, short release, long press, auto-repeat and release. The LED/OLED control logic consumes these pulses instead of raw levels. Each button has its own independent state machine and hold counter.

## Interface
- `WIDTH`, 4 — number of buttons.
- `LONG_CYCLES`, 50_000_000 — hold time before `long_o` fires (0.5 s at 100 MHz); legal range ≥2, <2**CNT_W.
- `REPEAT_CYCLES`, 10_000_000 — auto-repeat period after a long press; legal range ≥1, <2**CNT_W.
- `CNT_W`, 27 — hold counter width per button.
- `sclk  input  1  system clock; all logic is on its rising edge.`
- `resetn  input  1  reset, asynchronous and active-low; one clock.`
- `btn_in  input  WIDTH  debounced button levels, synchronous to sclk, 1 = pressed.`
- `press_o  output  WIDTH  1-cycle pulse on press.`
- `short_o  output  WIDTH  1-cycle pulse on release before the long threshold.`
- `long_o  output  WIDTH  1-cycle pulse when the hold reaches LONG_CYCLES.`
- `rpt_o  output  WIDTH  1-cycle pulse every REPEAT_CYCLES after long_o while still held.`
- `release_o  output  WIDTH  1-cycle pulse on every release.`
- `held_o  output  WIDTH  level: button i state machine is not IDLE.`

## Operation
- Per button i: state ∈ {IDLE, HELD, REPEAT} and counter `cnt[i]` (CNT_W bits). All outputs are registered.
- Pulse outputs default to 0 on every clock; each one is high for exactly one cycle per event.
- IDLE:
  - `btn_in[i]=1` → HELD, `cnt<=0`, `press_o[i]<=1`.
  - Otherwise stay in IDLE.
- HELD:
  - `btn_in[i]=0` → IDLE, `cnt<=0`, `short_o[i]<=1`, `release_o[i]<=1`.
  - Else if `cnt==LONG_CYCLES-1` → REPEAT, `cnt<=0`, `long_o[i]<=1`.
  - Else `cnt<=cnt+1`.
- REPEAT:
  - `btn_in[i]=0` → IDLE, `cnt<=0`, `release_o[i]<=1`, no `short_o`.
  - Else if `cnt==REPEAT_CYCLES-1` → `cnt<=0`, `rpt_o[i]<=1`.
  - Else `cnt<=cnt+1`.
- Release has priority: if a release and a threshold match fall on the same edge, only the release pulses are produced.
- `held_o[i]` is 1 in HELD and REPEAT, registered together with the state.
- Buttons are fully independent. Simultaneous presses or releases on any subset produce simultaneous pulses.
- The counter never exceeds `max(LONG_CYCLES, REPEAT_CYCLES)-1`, so no wrap-around is possible.
- Parameter legality is checked at elaboration; an illegal value is a fatal error.

## Timing
- Reset (`resetn=0`, asynchronous): every state goes to IDLE, every `cnt` to 0, and every output to 0 immediately.
  - Outputs stay 0 while reset is asserted.
  - A reset during a hold produces no release pulse.
- After reset deasserts with `btn_in[i]` already high: the first `sclk` edge is treated as a fresh press, and `press_o[i]` is high in the following cycle.
- Take edge e0 as the first edge that samples `btn_in[i]=1` from IDLE:
  - `press_o` is high in cycle e0→e1 (latency 1).
  - `long_o` pulses after edge e(LONG_CYCLES).
  - `rpt_o` pulses after edges e(LONG_CYCLES + k·REPEAT_CYCLES), k ≥ 1.
- Release latency is 1 cycle from the first edge that samples `btn_in[i]=0`.
- Minimum press that yields `long_o`: LONG_CYCLES+1 sampled-high edges. Exactly LONG_CYCLES high edges yields short+release.
- A 1-cycle press (one high sample) yields `press_o` then short+release on consecutive cycles.

## Test plan
All scenarios use WIDTH=4, LONG_CYCLES=8, REPEAT_CYCLES=3.
1. Reset: hold `resetn=0` for 5 cycles with `btn_in=4'h0`, then release → all outputs 0 throughout and after.
2. Short press: `btn_in[0]=1` for 5 edges (e0–e4), 0 at e5 → `press_o[0]` after e0; `short_o[0]` and `release_o[0]` after e5; no `long_o`/`rpt_o`; `held_o[0]` high for cycles e0–e5.
3. Long + repeat with release priority: `btn_in[1]=1` for e0–e19, 0 at e20 → `press_o` after e0; `long_o` after e8; `rpt_o` after e11, e14, e17; at e20 only `release_o[1]` (no `rpt_o`, no `short_o`).
4. Threshold boundary:
   - High for exactly 8 edges → short+release after e8, no `long_o`.
   - High for 9 edges → `long_o` after e8, then `release_o` only after e9.
5. Independence: `btn_in[0]` and `btn_in[3]` rise on the same edge; bit 0 held for 3 edges, bit 3 for 12 edges → simultaneous `press_o=4'b1001`; bit 0 short+release after e3; bit 3 long after e8, rpt after e11, release after e12; bits 1–2 stay 0.
6. Reset mid-hold: while button 2 is in REPEAT, assert `resetn=0` asynchronously between edges → all outputs drop immediately, no `release_o`. Deassert with `btn_in[2]` still 1 → `press_o[2]` after the next edge, and the count restarts from 0.

Source files
------------

// File: rtl/btn_event.sv
// btn_event: per-button event generator fed by debounced, sclk-synchronous
// button levels. Each button runs its own IDLE/HELD/REPEAT machine and hold
// timer, and produces registered single-cycle event pulses.
//
// Ports
//   sclk       system clock, rising edge
//   resetn     asynchronous active-low reset
//   btn_in     debounced button levels, 1 = pressed
//   press_o    1-cycle pulse on press
//   short_o    1-cycle pulse on release before the long threshold
//   long_o     1-cycle pulse when the hold reaches LONG_CYCLES
//   rpt_o      1-cycle pulse every REPEAT_CYCLES after long_o while held
//   release_o  1-cycle pulse on every release
//   held_o     level, button machine is not IDLE
//
// state  | meaning
// IDLE   | button released, waiting for a press
// HELD   | pressed, timing towards the long-press threshold
// REPEAT | long press reached, emitting auto-repeat pulses
//
// The hold timer is a down-counter loaded with (period-1) and compared
// against zero; a press sampled on edge e0 loads LONG_CYCLES-1, so the
// terminal count is seen on edge e(LONG_CYCLES).

module btn_event #(
   parameter int WIDTH         = 4,
   parameter int LONG_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000,
   parameter int CNT_W         = 27
) (
   input  logic             sclk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] btn_in,
   output logic [WIDTH-1:0] press_o,
   output logic [WIDTH-1:0] short_o,
   output logic [WIDTH-1:0] long_o,
   output logic [WIDTH-1:0] rpt_o,
   output logic [WIDTH-1:0] release_o,
   output logic [WIDTH-1:0] held_o
);

   if (CNT_W < 1 || CNT_W > 62) begin : g_bad_cnt_w
      $fatal(1, "btn_event: CNT_W out of range");
   end
   if (LONG_CYCLES < 2 || 64'(LONG_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_long
      $fatal(1, "btn_event: LONG_CYCLES out of range");
   end
   if (REPEAT_CYCLES < 1 || 64'(REPEAT_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_repeat
      $fatal(1, "btn_event: REPEAT_CYCLES out of range");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HELD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LOAD   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   for (genvar i = 0; i < WIDTH; i++) begin : g_btn
      state_t           state;
      state_t           nxt_state;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] nxt_cnt;
      logic             press_q,   nxt_press;
      logic             short_q,   nxt_short;
      logic             long_q,    nxt_long;
      logic             rpt_q,     nxt_rpt;
      logic             release_q, nxt_release;
      logic             tc;

      assign tc = (cnt == CNT_ZERO);

      always_ff @(posedge sclk or negedge resetn) begin
         if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            press_q   <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            rpt_q     <= 1'b0;
            release_q <= 1'b0;
         end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            press_q   <= nxt_press;
            short_q   <= nxt_short;
            long_q    <= nxt_long;
            rpt_q     <= nxt_rpt;
            release_q <= nxt_release;
         end
      end

      // Release is tested before the terminal count, so a release landing
      // on a threshold edge suppresses long/rpt.
      always_comb begin
         nxt_state = state;
         nxt_cnt   = cnt;
         case (state)
            IDLE: begin
               if (btn_in[i]) begin
                  nxt_state = HELD;
                  nxt_cnt   = LONG_LOAD;
               end
            end
            HELD: begin
               if (!btn_in[i]) begin
                  nxt_state = IDLE;
                  nxt_cnt   = '0;
               end else if (tc) begin
                  nxt_state = REPEAT;
                  nxt_cnt   = REPEAT_LOAD;
               end else begin
                  nxt_cnt   = cnt - CNT_ONE;
               end
            end
            REPEAT: begin
               if (!btn_in[i]) begin
                  nxt_state = IDLE;
                  nxt_cnt   = '0;
               end else if (tc) begin
                  nxt_cnt   = REPEAT_LOAD;
               end else begin
                  nxt_cnt   = cnt - CNT_ONE;
               end
            end
            default: begin
               nxt_state = IDLE;
               nxt_cnt   = '0;
            end
         endcase
      end

      always_comb begin
         nxt_press   = 1'b0;
         nxt_short   = 1'b0;
         nxt_long    = 1'b0;
         nxt_rpt     = 1'b0;
         nxt_release = 1'b0;
         case (state)
            IDLE: begin
               nxt_press = btn_in[i];
            end
            HELD: begin
               if (!btn_in[i]) begin
                  nxt_short   = 1'b1;
                  nxt_release = 1'b1;
               end else begin
                  nxt_long    = tc;
               end
            end
            REPEAT: begin
               if (!btn_in[i]) begin
                  nxt_release = 1'b1;
               end else begin
                  nxt_rpt     = tc;
               end
            end
            default: ;
         endcase
      end

      assign press_o[i]   = press_q;
      assign short_o[i]   = short_q;
      assign long_o[i]    = long_q;
      assign rpt_o[i]     = rpt_q;
      assign release_o[i] = release_q;
      assign held_o[i]    = (state != IDLE);
   end

endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event with WIDTH=4, LONG_CYCLES=8, REPEAT_CYCLES=3.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge. Each table vector is {btn_in for the next edge, expected
// outputs after that edge}.

module tb_btn_event;

   localparam int W = 4;
   localparam int L = 8;
   localparam int R = 3;

   logic         sclk;
   logic         resetn;
   logic [W-1:0] btn_in;
   logic [W-1:0] press_o, short_o, long_o, rpt_o, release_o, held_o;

   btn_event #(
      .WIDTH        (W),
      .LONG_CYCLES  (L),
      .REPEAT_CYCLES(R),
      .CNT_W        (5)
   ) dut (
      .sclk     (sclk),
      .resetn   (resetn),
      .btn_in   (btn_in),
      .press_o  (press_o),
      .short_o  (short_o),
      .long_o   (long_o),
      .rpt_o    (rpt_o),
      .release_o(release_o),
      .held_o   (held_o)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   typedef struct {
      int           sc;
      int           step;
      logic [W-1:0] btn;
      logic [W-1:0] press;
      logic [W-1:0] shrt;
      logic [W-1:0] lng;
      logic [W-1:0] rpt;
      logic [W-1:0] rel;
      logic [W-1:0] held;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void add(int sc, int step, logic [W-1:0] btn,
                               logic [W-1:0] press, logic [W-1:0] shrt,
                               logic [W-1:0] lng, logic [W-1:0] rpt,
                               logic [W-1:0] rel, logic [W-1:0] held);
      vec_t v;
      v.sc = sc; v.step = step; v.btn = btn;
      v.press = press; v.shrt = shrt; v.lng = lng;
      v.rpt = rpt; v.rel = rel; v.held = held;
      vecs.push_back(v);
   endfunction

   function automatic logic [6*W-1:0] outs();
      return {press_o, short_o, long_o, rpt_o, release_o, held_o};
   endfunction

   task automatic chk(string nm, logic [6*W-1:0] got, logic [6*W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s press/short/long/rpt/rel/held got %h want %h", nm, got, exp);
      end
   endtask

   initial begin
      resetn = 1'b0;
      btn_in = '0;

      // Scenario 2: short press on bit 0, 5 high edges then low.
      for (int e = 0; e <= 6; e++)
         add(2, e, (e < 5) ? 4'h1 : 4'h0,
             (e == 0) ? 4'h1 : 4'h0, (e == 5) ? 4'h1 : 4'h0, 4'h0, 4'h0,
             (e == 5) ? 4'h1 : 4'h0, (e < 5) ? 4'h1 : 4'h0);

      // Scenario 3: long + repeat on bit 1; release at e20 wins over rpt.
      for (int e = 0; e <= 21; e++)
         add(3, e, (e < 20) ? 4'h2 : 4'h0,
             (e == 0) ? 4'h2 : 4'h0, 4'h0, (e == 8) ? 4'h2 : 4'h0,
             (e == 11 || e == 14 || e == 17) ? 4'h2 : 4'h0,
             (e == 20) ? 4'h2 : 4'h0, (e < 20) ? 4'h2 : 4'h0);

      // Scenario 4a: exactly 8 high edges -> short+release at e8, no long.
      for (int e = 0; e <= 9; e++)
         add(4, e, (e < 8) ? 4'h1 : 4'h0,
             (e == 0) ? 4'h1 : 4'h0, (e == 8) ? 4'h1 : 4'h0, 4'h0, 4'h0,
             (e == 8) ? 4'h1 : 4'h0, (e < 8) ? 4'h1 : 4'h0);

      // Scenario 4b: 9 high edges -> long at e8, release only at e9.
      for (int e = 0; e <= 10; e++)
         add(5, e, (e < 9) ? 4'h1 : 4'h0,
             (e == 0) ? 4'h1 : 4'h0, 4'h0, (e == 8) ? 4'h1 : 4'h0, 4'h0,
             (e == 9) ? 4'h1 : 4'h0, (e < 9) ? 4'h1 : 4'h0);

      // Scenario 5: bits 0 and 3 together; bit 0 held 3 edges, bit 3 12.
      for (int e = 0; e <= 13; e++)
         add(6, e, {(e < 12), 2'b00, (e < 3)},
             (e == 0) ? 4'h9 : 4'h0,
             (e == 3) ? 4'h1 : 4'h0,
             (e == 8) ? 4'h8 : 4'h0,
             (e == 11) ? 4'h8 : 4'h0,
             (e == 3) ? 4'h1 : ((e == 12) ? 4'h8 : 4'h0),
             {(e < 12), 2'b00, (e < 3)});

      // Scenario 1: reset held 5 cycles, outputs stay 0.
      for (int c = 0; c < 5; c++) begin
         @(posedge sclk); #1;
         chk($sformatf("reset_hold_%0d", c), outs(), '0);
      end
      @(negedge sclk) resetn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge sclk); #1;
         chk($sformatf("post_reset_idle_%0d", c), outs(), '0);
      end

      // Table-driven scenarios.
      foreach (vecs[k]) begin
         @(negedge sclk) btn_in = vecs[k].btn;
         @(posedge sclk); #1;
         chk($sformatf("sc%0d_e%0d", vecs[k].sc, vecs[k].step), outs(),
             {vecs[k].press, vecs[k].shrt, vecs[k].lng,
              vecs[k].rpt, vecs[k].rel, vecs[k].held});
      end

      // Scenario 6: reset while bit 2 is in REPEAT and rpt_o is high.
      @(negedge sclk) btn_in = 4'h4;
      for (int e = 0; e <= 11; e++) begin
         @(posedge sclk); #1;
         if (e == 8)
            chk("rst6_long", outs(), {4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h4});
      end
      chk("rst6_rpt_before_reset", outs(), {4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h4});
      #2 resetn = 1'b0;
      #1 chk("rst6_async_drop", outs(), '0);
      for (int c = 0; c < 2; c++) begin
         @(posedge sclk); #1;
         chk($sformatf("rst6_held_in_reset_%0d", c), outs(), '0);
      end
      @(negedge sclk) resetn = 1'b1;
      // Count restarts: press at new e0, long exactly at new e8.
      for (int e = 0; e <= 8; e++) begin
         @(posedge sclk); #1;
         chk($sformatf("rst6_restart_e%0d", e), outs(),
             {(e == 0) ? 4'h4 : 4'h0, 4'h0, (e == 8) ? 4'h4 : 4'h0,
              4'h0, 4'h0, 4'h4});
      end
      @(negedge sclk) btn_in = 4'h0;
      @(posedge sclk); #1;
      chk("rst6_release", outs(), {4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0});
      @(posedge sclk); #1;
      chk("rst6_idle", outs(), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
